// File: rtl/bp_pkg.sv
// Shared branch-predictor types: default history length and checkpoint layout.
package bp_pkg;

    localparam int unsigned HIST_W_DEF = 4;

    typedef struct packed {
        logic                  taken;
        logic [HIST_W_DEF-1:0] hist;
    } bp_ckpt_t;

endpackage

// File: rtl/ckpt_fifo.sv
// Circular buffer of in-flight branch checkpoints with push, pop and clear.
module ckpt_fifo
    import bp_pkg::*;
#(
    parameter int unsigned DEPTH   = 8,
    parameter type         entry_t = bp_ckpt_t
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  entry_t                   push_data,
    input  logic                     pop,
    input  logic                     clear,
    output entry_t                   head_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int unsigned PTR_W = $clog2(DEPTH);

    entry_t           mem [DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic             do_push;
    logic             do_pop;

    assign full      = (count == ($clog2(DEPTH) + 1)'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push & ~full;
    assign do_pop    = pop & ~empty;
    assign head_data = mem[head];

    // Checkpoint storage; contents need no reset since count gates validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[tail] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; clear empties the buffer.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (do_push) begin
                tail <= tail + PTR_W'(1);
            end
            if (do_pop) begin
                head <= head + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ghr_ckpt_ctrl.sv
// Global history controller: speculative/committed history, checkpoint FIFO,
// mispredict/flush recovery and registered PHT update outputs.
module ghr_ckpt_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned HIST_W = HIST_W_DEF,
    parameter int unsigned DEPTH  = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pred_valid,
    input  logic                     pred_taken,
    output logic                     pred_ready,
    output logic [HIST_W-1:0]        spec_hist,
    input  logic                     res_valid,
    input  logic                     res_taken,
    input  logic                     flush,
    output logic                     upd_valid,
    output logic [HIST_W-1:0]        upd_hist,
    output logic                     upd_taken,
    output logic                     mispredict,
    output logic [$clog2(DEPTH):0]   count
);

    typedef struct packed {
        logic              taken;
        logic [HIST_W-1:0] hist;
    } ckpt_t;

    logic [HIST_W-1:0] commit_hist;
    logic [HIST_W-1:0] commit_next;
    logic [HIST_W-1:0] spec_next;
    ckpt_t             push_data;
    ckpt_t             head_data;
    logic              full;
    logic              empty;
    logic              accept;
    logic              do_res;
    logic              mis;
    logic              clear;

    assign pred_ready = ~full;
    assign accept     = pred_valid & pred_ready;
    assign do_res     = res_valid & ~empty;
    assign mis        = do_res & (head_data.taken != res_taken);
    assign clear      = mis | flush;
    assign push_data  = '{taken: pred_taken, hist: spec_hist};

    ckpt_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (ckpt_t)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (accept & ~clear),
        .push_data (push_data),
        .pop       (do_res),
        .clear     (clear),
        .head_data (head_data),
        .count     (count),
        .full      (full),
        .empty     (empty)
    );

    // Next committed and speculative history; recovery restores from the
    // post-resolve committed value so a same-cycle correct resolve is kept.
    always_comb begin
        commit_next = commit_hist;
        if (do_res) begin
            commit_next = {commit_hist[HIST_W-2:0], res_taken};
        end
        spec_next = spec_hist;
        if (mis || flush) begin
            spec_next = commit_next;
        end else if (accept) begin
            spec_next = {spec_hist[HIST_W-2:0], pred_taken};
        end
    end

    // History registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            spec_hist   <= '0;
            commit_hist <= '0;
        end else begin
            spec_hist   <= spec_next;
            commit_hist <= commit_next;
        end
    end

    // Registered PHT update and mispredict pulses.
    always_ff @(posedge clk) begin
        if (rst) begin
            upd_valid  <= 1'b0;
            upd_hist   <= '0;
            upd_taken  <= 1'b0;
            mispredict <= 1'b0;
        end else begin
            upd_valid  <= do_res;
            mispredict <= mis;
            if (do_res) begin
                upd_hist  <= head_data.hist;
                upd_taken <= res_taken;
            end
        end
    end

endmodule

// File: tb/tb_ghr_ckpt_ctrl.sv
// Directed self-checking bench for ghr_ckpt_ctrl (HIST_W=4, DEPTH=8).
module tb_ghr_ckpt_ctrl;

    logic       clk = 1'b0;
    logic       rst;
    logic       pred_valid;
    logic       pred_taken;
    logic       pred_ready;
    logic [3:0] spec_hist;
    logic       res_valid;
    logic       res_taken;
    logic       flush;
    logic       upd_valid;
    logic [3:0] upd_hist;
    logic       upd_taken;
    logic       mispredict;
    logic [3:0] count;

    int checks = 0;
    int errors = 0;

    ghr_ckpt_ctrl #(.HIST_W(4), .DEPTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .pred_valid (pred_valid),
        .pred_taken (pred_taken),
        .pred_ready (pred_ready),
        .spec_hist  (spec_hist),
        .res_valid  (res_valid),
        .res_taken  (res_taken),
        .flush      (flush),
        .upd_valid  (upd_valid),
        .upd_hist   (upd_hist),
        .upd_taken  (upd_taken),
        .mispredict (mispredict),
        .count      (count)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic pv, input logic pt, input logic rv, input logic rt, input logic fl);
        pred_valid = pv;
        pred_taken = pt;
        res_valid  = rv;
        res_taken  = rt;
        flush      = fl;
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_spec"},  32'(spec_hist),  32'h0);
        chk({tag, "_count"}, 32'(count),      32'h0);
        chk({tag, "_ready"}, 32'(pred_ready), 32'h1);
        chk({tag, "_uv"},    32'(upd_valid),  32'h0);
        chk({tag, "_uh"},    32'(upd_hist),   32'h0);
        chk({tag, "_ut"},    32'(upd_taken),  32'h0);
        chk({tag, "_mis"},   32'(mispredict), 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 0);
        tick();
        tick();
        rst = 1'b0;
        chk_reset_outputs("reset");

        // Predictions T,N,T.
        drive(1, 1, 0, 0, 0); tick();
        chk("p1_spec", 32'(spec_hist), 32'h1);
        drive(1, 0, 0, 0, 0); tick();
        chk("p2_spec", 32'(spec_hist), 32'h2);
        drive(1, 1, 0, 0, 0); tick();
        chk("p3_spec",  32'(spec_hist),  32'h5);
        chk("p3_count", 32'(count),      32'd3);
        chk("p3_ready", 32'(pred_ready), 32'h1);

        // Resolve T,N,T correctly.
        drive(0, 0, 1, 1, 0); tick();
        chk("r1_uv", 32'(upd_valid), 32'h1);
        chk("r1_uh", 32'(upd_hist),  32'h0);
        chk("r1_ut", 32'(upd_taken), 32'h1);
        chk("r1_mis", 32'(mispredict), 32'h0);
        drive(0, 0, 1, 0, 0); tick();
        chk("r2_uh", 32'(upd_hist),  32'h1);
        chk("r2_ut", 32'(upd_taken), 32'h0);
        chk("r2_mis", 32'(mispredict), 32'h0);
        drive(0, 0, 1, 1, 0); tick();
        chk("r3_uv", 32'(upd_valid), 32'h1);
        chk("r3_uh", 32'(upd_hist),  32'h2);
        chk("r3_count", 32'(count),  32'd0);
        drive(0, 0, 0, 0, 0); tick();
        chk("r4_uv", 32'(upd_valid), 32'h0);

        // Fill with 8 taken predictions from spec 0101.
        for (int i = 0; i < 8; i++) begin
            drive(1, 1, 0, 0, 0); tick();
        end
        chk("fill_count", 32'(count),      32'd8);
        chk("fill_ready", 32'(pred_ready), 32'h0);
        chk("fill_spec",  32'(spec_hist),  32'hF);
        drive(1, 0, 0, 0, 0); tick();
        chk("full9_count", 32'(count),     32'd8);
        chk("full9_spec",  32'(spec_hist), 32'hF);
        // Correct resolve plus blocked prediction in the same cycle.
        drive(1, 0, 1, 1, 0); tick();
        chk("fullres_count", 32'(count),      32'd7);
        chk("fullres_spec",  32'(spec_hist),  32'hF);
        chk("fullres_uh",    32'(upd_hist),   32'h5);
        chk("fullres_mis",   32'(mispredict), 32'h0);
        chk("fullres_ready", 32'(pred_ready), 32'h1);

        // Flush restores committed history 1011.
        drive(0, 0, 0, 0, 1); tick();
        chk("fl1_spec",  32'(spec_hist), 32'hB);
        chk("fl1_count", 32'(count),     32'd0);
        chk("fl1_uv",    32'(upd_valid), 32'h0);

        // Drive commit to 0011 via N,N,T,T predicted and resolved correctly.
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("c3_spec", 32'(spec_hist), 32'h3);
        drive(0, 0, 1, 0, 0); tick();
        chk("c3_uh1", 32'(upd_hist), 32'hB);
        drive(0, 0, 1, 0, 0); tick();
        drive(0, 0, 1, 1, 0); tick();
        chk("c3_uh3", 32'(upd_hist), 32'hC);
        drive(0, 0, 1, 1, 0); tick();
        chk("c3_uh4",   32'(upd_hist), 32'h9);
        chk("c3_count", 32'(count),    32'd0);

        // Predict T,T then resolve first as N with a same-cycle prediction.
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 1, 0, 0, 0); tick();
        chk("mp_pre_spec", 32'(spec_hist), 32'hF);
        drive(1, 1, 1, 0, 0); tick();
        chk("mp_mis",   32'(mispredict), 32'h1);
        chk("mp_spec",  32'(spec_hist),  32'h6);
        chk("mp_count", 32'(count),      32'd0);
        chk("mp_uv",    32'(upd_valid),  32'h1);
        chk("mp_uh",    32'(upd_hist),   32'h3);
        chk("mp_ut",    32'(upd_taken),  32'h0);
        drive(0, 0, 0, 0, 0); tick();
        chk("mp_pulse", 32'(mispredict), 32'h0);
        chk("mp_uv0",   32'(upd_valid),  32'h0);

        // Reset, then commit 0001.
        rst = 1'b1; tick(); rst = 1'b0;
        drive(1, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 0); tick();
        chk("c1_count", 32'(count), 32'd0);
        // Two outstanding predictions then flush with a dropped prediction.
        drive(1, 1, 0, 0, 0); tick();
        drive(1, 0, 0, 0, 0); tick();
        chk("fl2_pre_spec",  32'(spec_hist), 32'h6);
        chk("fl2_pre_count", 32'(count),     32'd2);
        drive(1, 1, 0, 0, 1); tick();
        chk("fl2_spec",  32'(spec_hist), 32'h1);
        chk("fl2_count", 32'(count),     32'd0);
        // Flush together with a correct resolve.
        drive(1, 1, 0, 0, 0); tick();
        drive(0, 0, 1, 1, 1); tick();
        chk("flr_spec",  32'(spec_hist),  32'h3);
        chk("flr_uv",    32'(upd_valid),  32'h1);
        chk("flr_uh",    32'(upd_hist),   32'h1);
        chk("flr_mis",   32'(mispredict), 32'h0);
        chk("flr_count", 32'(count),      32'd0);

        // Resolve on an empty FIFO is ignored.
        drive(0, 0, 1, 0, 0); tick();
        chk("emp_uv",    32'(upd_valid),  32'h0);
        chk("emp_mis",   32'(mispredict), 32'h0);
        chk("emp_spec",  32'(spec_hist),  32'h3);
        chk("emp_count", 32'(count),      32'd0);

        // Five in flight, then reset mid-operation.
        for (int i = 0; i < 5; i++) begin
            drive(1, 1, 0, 0, 0); tick();
        end
        chk("r5_count", 32'(count),     32'd5);
        chk("r5_spec",  32'(spec_hist), 32'hF);
        drive(0, 0, 1, 1, 0); tick();
        chk("r5_uv", 32'(upd_valid), 32'h1);
        rst = 1'b1;
        drive(1, 1, 1, 0, 0); tick();
        rst = 1'b0;
        drive(0, 0, 0, 0, 0);
        chk_reset_outputs("midrst");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
